// File: rtl/neuron_accum_l2.sv
// Layer-2 neuron: MAC over N_IN (act, wt) pairs, shift/saturate to 7b,
// drive sigmoid LUT, hand result downstream on valid/ready.
// Ports: clk, rst_n (async low), start, in_valid/in_ready/act_in/wt_in,
//        sig_in -> LUT, sig_out <- LUT, out_valid/out_ready/out_data, busy.
// Optional: NEURON_L2_BIAS_EN adds bias_in (7b signed), preloads the
//           accumulator with sext(bias_in) << SHIFT on start.
module neuron_accum_l2 #(
  parameter int N_IN  = 10,
  parameter int ACC_W = 18,
  parameter int SHIFT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] act_in,
  input  logic [6:0] wt_in,
`ifdef NEURON_L2_BIAS_EN
  input  logic [6:0] bias_in,
`endif
  output logic [6:0] sig_in,
  input  logic [6:0] sig_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    QUANT,
    LOOKUP,
    OUTPUT
  } state_e;

  localparam logic [7:0] LAST = 8'(N_IN - 1);

  state_e                   state_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic        [7:0]        cnt_q;
  logic        [6:0]        sig_q;
  logic        [6:0]        out_data_q;
  logic                     out_valid_q;
  logic                     in_ready_q;
  logic                     busy_q;

  logic signed [13:0]       act_x;
  logic signed [13:0]       wt_x;
  logic signed [13:0]       prod;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_init;
  logic signed [ACC_W-1:0]  q;
  logic        [ACC_W-7:0]  q_hi;
  logic                     q_fits;
  logic        [6:0]        sig_d;
  logic                     accept;

  // act is unsigned, so zero-extend; wt is two's complement.
  assign act_x = {7'b0, act_in};
  assign wt_x  = {{7{wt_in[6]}}, wt_in};
  assign prod  = act_x * wt_x;
  assign acc_d = acc_q + {{(ACC_W-14){prod[13]}}, prod};

`ifdef NEURON_L2_BIAS_EN
  assign acc_init = {{(ACC_W-7){bias_in[6]}}, bias_in} <<< SHIFT;
`else
  assign acc_init = '0;
`endif

  // q fits in 7b signed iff every bit from 6 upward matches the sign.
  assign q      = acc_q >>> SHIFT;
  assign q_hi   = q[ACC_W-1:6];
  assign q_fits = (&q_hi) | ~(|q_hi);
  assign sig_d  = q_fits       ? q[6:0] :
                  q[ACC_W-1]   ? 7'h40  : 7'h3F;

  assign accept = in_valid & in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sig_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            acc_q      <= acc_init;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == LAST) begin
              state_q    <= QUANT;
              in_ready_q <= 1'b0;
            end
          end
        end
        QUANT: begin
          sig_q   <= sig_d;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          out_data_q  <= sig_out;
          out_valid_q <= 1'b1;
          state_q     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign sig_in    = sig_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_accum_l2.sv
// Directed bench for neuron_accum_l2 with a stand-in LUT (sig ^ 7'h5A).
// Define NEURON_L2_BIAS_EN to also exercise the bias preload.
module tb_neuron_accum_l2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] act_in;
  logic [6:0] wt_in;
  logic [6:0] sig_in;
  logic [6:0] sig_out;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       busy;
`ifdef NEURON_L2_BIAS_EN
  logic [6:0] bias_in;
`endif

  int checks = 0;
  int fails  = 0;

  neuron_accum_l2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act_in    (act_in),
    .wt_in     (wt_in),
`ifdef NEURON_L2_BIAS_EN
    .bias_in   (bias_in),
`endif
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  assign sig_out = sig_in ^ 7'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] lut(input logic [6:0] x);
    return x ^ 7'h5A;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Feed npairs pairs; with stall set, valid only every third cycle and
  // junk data plus stray start pulses on the idle cycles.
  task automatic feed(input logic [6:0] a, input logic [6:0] w,
                      input int npairs, input bit stall);
    int n;
    int cyc;
    bit acc;
    n   = 0;
    cyc = 0;
    while (n < npairs && cyc < 200) begin
      in_valid = stall ? (cyc % 3 == 0) : 1'b1;
      act_in   = in_valid ? a : 7'h7F;
      wt_in    = in_valid ? w : 7'h3F;
      start    = stall && (cyc % 3 == 1);
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) n++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("pairs_fed", n, npairs);
  endtask

  task automatic eval(input string tag, input logic [6:0] a,
                      input logic [6:0] w, input logic [6:0] exp,
                      input bit stall, input int hold);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rdy"}, in_ready, 1);
    feed(a, w, 10, stall);
    // extra pairs offered after the 10th must not be taken
    in_valid = 1'b1;
    act_in   = 7'h7F;
    wt_in    = 7'h3F;
    chk({tag, "_rdy_q"}, in_ready, 0);
    chk({tag, "_ov_k"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_sig"}, sig_in, exp);
    chk({tag, "_ov_k1"}, out_valid, 0);
    chk({tag, "_rdy_l"}, in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_ov_k2"}, out_valid, 1);
    chk({tag, "_od"}, out_data, lut(exp));
    for (int i = 0; i < hold; i++) begin
      start = (i == 1);
      @(negedge clk);
      chk({tag, "_hold_ov"}, out_valid, 1);
      chk({tag, "_hold_od"}, out_data, lut(exp));
      chk({tag, "_hold_sig"}, sig_in, exp);
    end
    // handshake cycle with a start pulse that must be ignored
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_ov_drop"}, out_valid, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_sig_keep"}, sig_in, exp);
    @(negedge clk);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    act_in    = '0;
    wt_in     = '0;
    out_ready = 1'b0;
`ifdef NEURON_L2_BIAS_EN
    bias_in   = '0;
`endif
    #12;
    chk("rst_sig", sig_in, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    eval("pos", 7'd16, 7'd2, 7'h14, 1'b0, 0);
    eval("sat_hi", 7'd32, 7'd5, 7'h3F, 1'b0, 0);
    eval("sat_lo", 7'd100, 7'h76, 7'h40, 1'b0, 0);
    eval("neg", 7'd8, 7'h7D, 7'h71, 1'b0, 0);
    eval("stall", 7'd16, 7'd2, 7'h14, 1'b1, 5);

    // abort after 6 pairs; previous run left sig_in/out_data nonzero
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    feed(7'd100, 7'd50, 6, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("abort_sig", sig_in, 0);
    chk("abort_od", out_data, 0);
    chk("abort_ov", out_valid, 0);
    chk("abort_rdy", in_ready, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ov", out_valid, 0);
      chk("abort_idle", busy, 0);
    end
    eval("fresh", 7'd16, 7'd2, 7'h14, 1'b0, 1);

`ifdef NEURON_L2_BIAS_EN
    bias_in = 7'd5;
    eval("bias", 7'd0, 7'd9, 7'h05, 1'b0, 0);
    bias_in = 7'h7D;
    eval("bias_neg", 7'd16, 7'd2, 7'h11, 1'b0, 0);
    bias_in = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
